// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial ALU sequencer driving one external 1-bit ALU slice (optional overflow_flag via SERIAL_ALU_OVF_EN)
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic [2:0]       operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag,
`ifdef SERIAL_ALU_OVF_EN
    output logic             overflow_flag,
`endif
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic             alu_mode,
    output logic [2:0]       alu_op,
    input  logic             alu_out,
    input  logic             alu_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             mode_r;
    logic [2:0]       op_r;
    logic             carry_r;
    logic             nz_acc;
    logic             accept;
    logic             last;

    // Subtract, increment and A+B+1 start with carry-in set; logic ops never use it.
    function automatic logic init_cin(input logic m, input logic [2:0] op);
        if (m) begin
            return 1'b0;
        end
        return (op == 3'd1) || (op == 3'd2) || (op == 3'd6);
    endfunction

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == LAST);
    assign busy   = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_a    = 1'b0;
        alu_b    = 1'b0;
        alu_cin  = 1'b0;
        alu_mode = 1'b0;
        alu_op   = 3'd0;
        if (state == RUN) begin
            alu_a    = a_sh[0];
            alu_b    = b_sh[0];
            alu_cin  = carry_r;
            alu_mode = mode_r;
            alu_op   = op_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            mode_r     <= 1'b0;
            op_r       <= 3'd0;
            carry_r    <= 1'b0;
            nz_acc     <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            overflow_flag <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                res_sh  <= '0;
                cnt     <= '0;
                mode_r  <= mode;
                op_r    <= operation;
                carry_r <= init_cin(mode, operation);
                nz_acc  <= 1'b0;
            end else if (state == RUN) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                res_sh  <= {alu_out, res_sh[WIDTH-1:1]};
                carry_r <= alu_cout;
                nz_acc  <= nz_acc | alu_out;
                cnt     <= cnt + 1'b1;
                if (last) begin
                    // Final bit goes straight into the result so flags and data land together with done.
                    done       <= 1'b1;
                    result     <= {alu_out, res_sh[WIDTH-1:1]};
                    carry_flag <= mode_r ? 1'b0 : alu_cout;
                    zero_flag  <= ~(nz_acc | alu_out);
`ifdef SERIAL_ALU_OVF_EN
                    overflow_flag <= mode_r ? 1'b0 : (carry_r ^ alu_cout);
`endif
                end
            end
        end
    end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal values 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only while busy=0.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 SHALL have port mode  input  1  0=arithmetic, 1=logic; captured when start is accepted.
REQ-008 SHALL have port operation  input  3  opcode, captured when start is accepted.
REQ-009 SHALL have port busy  output  1  high while a bit-serial operation runs.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-011 SHALL have port result  output  WIDTH  completed result, held until next accepted start completes.
REQ-012 SHALL have ports carry_flag / zero_flag  output  1 each  final carry and all-zero result.
REQ-013 SHALL have ALU-side ports alu_a, alu_b, alu_cin, alu_mode (output, 1 each), alu_op (output, 3) and alu_out, alu_cout (input, 1 each), connecting to one external 1-bit ALU slice.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start with busy=0; RUN->IDLE after WIDTH bit cycles.
REQ-015 SHALL, on accept, load A/B shift registers, latch mode/op, zero the bit counter, and set carry register to the initial cin.
REQ-016 SHALL set initial cin by op (mode=0): 0->0 ADD, 1->1 SUB, 2->1 INC, 3->0, 4->0 PASS A, 5->0 DEC, 6->1 A+B+1, 7->0.
REQ-017 SHALL in RUN present bit i (LSB first) of A/B on alu_a/alu_b in RUN cycle i, with alu_cin = carry register, alu_mode/alu_op = latched values; ALU outputs are combinational in the same cycle.
REQ-018 SHALL each RUN cycle shift alu_out into result-shift MSB side, update carry register with alu_cout, and OR alu_out into a nonzero accumulator.
REQ-019 SHALL, outside RUN, drive all alu_* outputs to 0.
REQ-020 SHALL give latency: start accepted in cycle 0, RUN cycles 1..WIDTH, done=1 and result/flags updated in cycle WIDTH+1, busy=0 in that cycle.
REQ-021 SHALL set carry_flag = alu_cout of bit WIDTH-1 when mode=0, and 0 when mode=1.
REQ-022 SHALL set zero_flag = 1 iff all WIDTH result bits are 0, for both modes.
REQ-023 SHALL ignore start while busy=1; latched operands and sequence unaffected.
REQ-024 SHALL accept start in the same cycle done=1 (back-to-back), giving a new done exactly WIDTH+1 cycles later.
REQ-025 SHALL keep result/flags stable between done pulses; operand input changes during RUN have no effect.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear busy, done, result, carry_flag, zero_flag, all shift registers, counter and alu_* outputs to 0.
REQ-027 SHALL, on reset during RUN, abandon the operation with no done pulse and no result update after reset release.
REQ-028 SHALL accept a start in the first cycle after rst_n returns high.

Configuration
REQ-029 SHALL, with macro SERIAL_ALU_OVF_EN defined, add output overflow_flag (1) = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 when mode=0, else 0, updated with done, cleared by reset.
REQ-030 SHALL, without SERIAL_ALU_OVF_EN, omit overflow_flag port and its logic; all other behaviour identical.

Verification (WIDTH=8, real 1-bit ALU slice attached)
REQ-031 SHALL cover ADD: a=0x7F, b=0x01, mode=0, op=0 -> done in cycle 9, result=0x80, carry=0, zero=0, overflow=1 (macro on).
REQ-032 SHALL cover SUB: a=0x05, b=0x05, op=1 -> result=0x00, carry=1, zero=1; INC a=0xFF op=2 -> result=0x00, carry=1, zero=1.
REQ-033 SHALL cover logic: a=0xF0, b=0xFF, mode=1, op=2 -> result=0x0F, carry=0, zero=0.
REQ-034 SHALL cover start pulsed in RUN cycle 3 with different operands -> ignored; single done with first operation's result.
REQ-035 SHALL cover rst_n=0 in RUN cycle 4 -> all outputs 0 next cycle, no done; subsequent start of DEC a=0x00 op=5 -> result=0xFF, carry=0.
REQ-036 SHALL cover back-to-back: second start in done cycle -> second done exactly 9 cycles later with correct result.
